// File: rtl/bk_spi_xfer_seq_pkg.sv
// Shared definitions for the BKP SPI transaction sequencer.
// Contents: register offsets inside the SPI master window, bk_status bit
// positions, continue/done codes and the sequencer state encoding.
package bk_spi_xfer_seq_pkg;

    // Register offsets relative to the SPI master base index.
    localparam logic [3:0] OFF_DESR      = 4'd0;
    localparam logic [3:0] OFF_MODE      = 4'd1;
    localparam logic [3:0] OFF_RW        = 4'd2;
    localparam logic [3:0] OFF_T1BIT     = 4'd3;
    localparam logic [3:0] OFF_TXDATA    = 4'd4;
    localparam logic [3:0] OFF_RXACK     = 4'd5;
    localparam logic [3:0] OFF_START     = 4'd6;
    localparam logic [3:0] OFF_SS        = 4'd7;
    localparam logic [3:0] OFF_CONTDONE  = 4'd8;
    localparam logic [3:0] OFF_RECCLEAN  = 4'd9;

    // bk_status bit positions while bk_mode = 0.
    localparam int ST_BUSY = 0;
    localparam int ST_CONT = 1;
    localparam int ST_RECV = 2;

    // Values written to the continue/done register.
    localparam logic [31:0] CD_IDLE = 32'd0;
    localparam logic [31:0] CD_CONT = 32'd1;
    localparam logic [31:0] CD_DONE = 32'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_START, S_TXWAIT, S_SEND, S_POLLHI,
        S_POLLLO, S_RXWAIT, S_NEXT, S_FINISH, S_ABORT
    } state_e;

    // abs_zero selects absolute index 0 (bk_mode) instead of base+offset.
    function automatic logic [31:0] reg_index(input logic [31:0] base,
                                              input logic        abs_zero,
                                              input logic [3:0]  off);
        return abs_zero ? 32'd0 : base + {28'd0, off};
    endfunction

endpackage

// File: rtl/bk_spi_xfer_seq_writer.sv
// BKP write primitive.
// Latches index/value on req_i, holds ready_o high for HOLD cycles, then low
// for GAP cycles, then pulses done_o. index_o/value_o stay unchanged until the
// next request, so they are stable over the whole HOLD+GAP window.
// Ports: req_i/idx_i/val_i request, done_o completion pulse,
//        ready_o/index_o/value_o drive the BKP bus.
module bk_spi_xfer_seq_writer #(
    parameter int HOLD = 4,
    parameter int GAP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic [31:0] idx_i,
    input  logic [31:0] val_i,
    output logic        done_o,
    output logic        ready_o,
    output logic [31:0] index_o,
    output logic [31:0] value_o
);

    typedef enum logic [1:0] {P_IDLE, P_HOLD, P_GAP} phase_e;

    phase_e      phase_q;
    logic [15:0] cnt_q;
    logic        ready_q;
    logic        done_q;
    logic [31:0] idx_q;
    logic [31:0] val_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= P_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            val_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                P_IDLE: begin
                    if (req_i) begin
                        idx_q   <= idx_i;
                        val_q   <= val_i;
                        ready_q <= 1'b1;
                        cnt_q   <= 16'(HOLD - 1);
                        phase_q <= P_HOLD;
                    end
                end
                P_HOLD: begin
                    if (cnt_q == 16'd0) begin
                        ready_q <= 1'b0;
                        cnt_q   <= 16'(GAP - 1);
                        phase_q <= P_GAP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    if (cnt_q == 16'd0) begin
                        done_q  <= 1'b1;
                        phase_q <= P_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    assign done_o  = done_q;
    assign ready_o = ready_q;
    assign index_o = idx_q;
    assign value_o = val_q;

endmodule

// File: rtl/bk_spi_xfer_seq.sv
// Multi-byte SPI transaction sequencer for a BKP-configured SPI master.
// Takes a command (ss/mode/rw/t1bit/len) and a TX byte stream, performs the
// register write sequence on the BKP bus, polls bk_status_i and returns RX
// bytes. Ports: cmd_* command handshake, tx_* byte input, rx_* byte output,
// busy/done/err status, bkp_* register bus, bk_status_i master status.
module bk_spi_xfer_seq
    import bk_spi_xfer_seq_pkg::*;
#(
    parameter int BKP_BASE_index = 800,
    parameter int BKP_HOLD       = 4,
    parameter int BKP_GAP        = 4,
    parameter int STATUS_LAT     = 4,
    parameter int TIMEOUT_CYC    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_ss,
    input  logic [1:0]  cmd_mode,
    input  logic        cmd_rw,
    input  logic [31:0] cmd_t1bit,
    input  logic [7:0]  cmd_len,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bkp_ready_o,
    output logic [31:0] bkp_index_o,
    output logic [31:0] bkp_value_o,
    input  logic [31:0] bk_status_i
);

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] wait_q, wait_d;
    logic [1:0]  mode_q, mode_d;
    logic        rw_q, rw_d;
    logic [7:0]  ss_q, ss_d;
    logic [31:0] t1bit_q, t1bit_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  rx_q, rx_d;
    logic        rx_valid_q, rx_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        pend_q, pend_d;

    logic        wr_need, wr_abs, wr_req, wr_done, adv, tmo_hit;
    logic [3:0]  wr_off;
    logic [31:0] wr_val;
    logic        unused_status;

    assign unused_status = ^bk_status_i[31:8];

    // Which register write (if any) the current micro-step wants.
    always_comb begin
        wr_need = 1'b0;
        wr_abs  = 1'b0;
        wr_off  = OFF_DESR;
        wr_val  = 32'd0;
        case (state_q)
            S_CFG: begin
                wr_need = 1'b1;
                case (step_q)
                    4'd0:    wr_abs = 1'b1;
                    4'd1:    wr_val = 32'd1;
                    4'd2:    begin wr_off = OFF_MODE;  wr_val = {30'd0, mode_q}; end
                    4'd3:    begin wr_off = OFF_RW;    wr_val = {31'd0, rw_q};   end
                    4'd4:    begin wr_off = OFF_T1BIT; wr_val = t1bit_q;         end
                    4'd5:    begin wr_off = OFF_SS;    wr_val = {24'd0, ss_q};   end
                    4'd6:    begin wr_off = OFF_RECCLEAN; wr_val = 32'd1;        end
                    4'd7:    wr_off = OFF_RECCLEAN;
                    default: wr_off = OFF_CONTDONE;
                endcase
            end
            S_START: begin
                wr_need = 1'b1;
                wr_off  = OFF_START;
                wr_val  = {31'd0, step_q[0]};
            end
            S_SEND: begin
                wr_need = (step_q == 4'd0);
                wr_off  = OFF_TXDATA;
                wr_val  = {24'd0, byte_q};
            end
            S_RXWAIT: begin
                case (step_q)
                    4'd1: begin wr_need = 1'b1; wr_abs = 1'b1; wr_val = 32'd1; end
                    4'd2: begin wr_need = 1'b1; wr_off = OFF_RXACK; end
                    4'd4: begin wr_need = 1'b1; wr_abs = 1'b1; end
                    4'd5: begin wr_need = 1'b1; wr_off = OFF_RECCLEAN; wr_val = 32'd1; end
                    4'd6: begin wr_need = 1'b1; wr_off = OFF_RECCLEAN; end
                    default: ;
                endcase
            end
            S_NEXT: begin
                wr_need = 1'b1;
                wr_off  = OFF_CONTDONE;
                if (cnt_q != 8'd0) wr_val = (step_q == 4'd0) ? CD_CONT : CD_IDLE;
                else               wr_val = CD_DONE;
            end
            S_FINISH: begin
                wr_need = 1'b1;
                wr_off  = (step_q == 4'd0) ? OFF_CONTDONE : OFF_START;
            end
            S_ABORT: begin
                wr_need = 1'b1;
                case (step_q)
                    4'd0:    begin wr_off = OFF_CONTDONE; wr_val = CD_DONE; end
                    4'd1:    wr_off = OFF_CONTDONE;
                    4'd2:    wr_off = OFF_START;
                    default: wr_off = OFF_DESR;
                endcase
            end
            default: ;
        endcase
    end

    // A write is requested once per micro-step; pend_q blocks re-issue until done.
    assign wr_req  = wr_need & ~pend_q;
    assign adv     = wr_need & wr_done;
    assign tmo_hit = (wait_q >= 32'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        mode_d     = mode_q;
        rw_d       = rw_q;
        ss_d       = ss_q;
        t1bit_d    = t1bit_q;
        byte_d     = byte_q;
        rx_d       = rx_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        busy_d     = busy_q;
        pend_d     = pend_q;
        cmd_ready  = (state_q == S_IDLE);
        tx_ready   = 1'b0;

        if (wr_req)  pend_d = 1'b1;
        if (wr_done) pend_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    rw_d    = cmd_rw;
                    ss_d    = cmd_ss;
                    t1bit_d = cmd_t1bit;
                    cnt_d   = cmd_len;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    step_d  = 4'd0;
                    state_d = S_CFG;
                end
            end
            S_CFG: if (adv) begin
                step_d = step_q + 4'd1;
                if (step_q == 4'd8) begin step_d = 4'd0; state_d = S_START; end
            end
            S_START: if (adv) begin
                step_d = step_q + 4'd1;
                if (step_q == 4'd1) begin step_d = 4'd0; state_d = S_TXWAIT; end
            end
            S_TXWAIT: begin
                tx_ready = tx_valid;
                if (tx_valid) begin
                    byte_d  = tx_data;
                    step_d  = 4'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (step_q == 4'd0) begin
                    if (adv) begin step_d = 4'd1; wait_d = 32'd0; end
                end else if (wait_q == 32'(STATUS_LAT - 1)) begin
                    wait_d  = 32'd0;
                    state_d = S_POLLHI;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_POLLHI: begin
                if (bk_status_i[ST_BUSY]) begin
                    wait_d  = 32'd0;
                    state_d = S_POLLLO;
                end else if (tmo_hit) begin
                    step_d  = 4'd0;
                    state_d = S_ABORT;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_POLLLO: begin
                if (!bk_status_i[ST_BUSY]) begin
                    wait_d  = 32'd0;
                    step_d  = 4'd0;
                    state_d = rw_q ? S_RXWAIT : S_NEXT;
                end else if (tmo_hit) begin
                    step_d  = 4'd0;
                    state_d = S_ABORT;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_RXWAIT: begin
                case (step_q)
                    4'd0: begin
                        if (bk_status_i[ST_RECV]) begin
                            step_d = 4'd1;
                        end else if (tmo_hit) begin
                            state_d = S_ABORT;
                        end else begin
                            wait_d = wait_q + 32'd1;
                        end
                    end
                    4'd3: begin
                        // bk_mode is 1 here, so the status word carries the RX byte.
                        if (wait_q == 32'(STATUS_LAT - 1)) begin
                            rx_d       = bk_status_i[7:0];
                            rx_valid_d = 1'b1;
                            step_d     = 4'd4;
                        end else begin
                            wait_d = wait_q + 32'd1;
                        end
                    end
                    default: if (adv) begin
                        step_d = step_q + 4'd1;
                        wait_d = 32'd0;
                        if (step_q == 4'd6) begin step_d = 4'd0; state_d = S_NEXT; end
                    end
                endcase
            end
            S_NEXT: if (adv) begin
                if (cnt_q == 8'd0) begin
                    step_d  = 4'd0;
                    state_d = S_FINISH;
                end else if (step_q == 4'd0) begin
                    step_d = 4'd1;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    step_d  = 4'd0;
                    state_d = S_TXWAIT;
                end
            end
            S_FINISH: if (adv) begin
                step_d = step_q + 4'd1;
                if (step_q == 4'd1) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ABORT: if (adv) begin
                step_d = step_q + 4'd1;
                if (step_q == 4'd3) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            mode_q     <= '0;
            rw_q       <= 1'b0;
            ss_q       <= '0;
            t1bit_q    <= '0;
            byte_q     <= '0;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            mode_q     <= mode_d;
            rw_q       <= rw_d;
            ss_q       <= ss_d;
            t1bit_q    <= t1bit_d;
            byte_q     <= byte_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    bk_spi_xfer_seq_writer #(
        .HOLD (BKP_HOLD),
        .GAP  (BKP_GAP)
    ) u_writer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (wr_req),
        .idx_i   (reg_index(32'(BKP_BASE_index), wr_abs, wr_off)),
        .val_i   (wr_val),
        .done_o  (wr_done),
        .ready_o (bkp_ready_o),
        .index_o (bkp_index_o),
        .value_o (bkp_value_o)
    );

endmodule

// File: tb/tb_bk_spi_xfer_seq.sv
// Bench for bk_spi_xfer_seq: a behavioural SPI master (register file reacting
// to BKP writes) drives bk_status; expected BKP write lists and RX streams are
// built from the transaction rules and compared against what the DUT produced.
module tb_bk_spi_xfer_seq;
    localparam int BASE = 800;
    localparam int HOLD = 4;
    localparam int GAP  = 4;
    localparam int LAT  = 4;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [7:0]  cmd_ss = '0, cmd_len = '0;
    logic [1:0]  cmd_mode = '0;
    logic [31:0] cmd_t1bit = '0;
    logic        tx_valid = 1'b0, tx_ready;
    logic [7:0]  tx_data = '0;
    logic        rx_valid, busy, done, err;
    logic [7:0]  rx_data;
    logic        bkp_ready_o;
    logic [31:0] bkp_index_o, bkp_value_o, bk_status;

    always #5 clk = ~clk;

    bk_spi_xfer_seq #(
        .BKP_BASE_index(BASE), .BKP_HOLD(HOLD), .BKP_GAP(GAP),
        .STATUS_LAT(LAT), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ss(cmd_ss),
        .cmd_mode(cmd_mode), .cmd_rw(cmd_rw), .cmd_t1bit(cmd_t1bit), .cmd_len(cmd_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .done(done), .err(err),
        .bkp_ready_o(bkp_ready_o), .bkp_index_o(bkp_index_o), .bkp_value_o(bkp_value_o),
        .bk_status_i(bk_status)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- SPI master model ----------------
    logic       m_mode, m_rw, m_recv, m_rdy_prev;
    logic       m_stuck = 1'b0;
    int         m_tm, m_bidx, m_t1;
    logic [7:0] m_rxb;
    logic [7:0] rx_src[$];
    logic       m_busy;

    assign m_busy    = (m_tm >= 3) && (m_tm < 3 + 8 * m_t1);
    assign bk_status = m_mode ? {24'd0, m_rxb} : {29'd0, m_recv, 1'b0, m_busy | m_stuck};

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode <= 1'b0; m_rw <= 1'b0; m_recv <= 1'b0; m_rdy_prev <= 1'b0;
            m_tm <= -1; m_bidx <= 0; m_t1 <= 8; m_rxb <= 8'h00;
        end else begin
            m_rdy_prev <= bkp_ready_o;
            if (m_tm >= 0) begin
                if (m_tm == 3 + 8 * m_t1) begin m_tm <= -1; m_recv <= m_rw; end
                else m_tm <= m_tm + 1;
            end
            if (bkp_ready_o && !m_rdy_prev) begin
                if (bkp_index_o == 32'd0) m_mode <= bkp_value_o[0];
                else if (bkp_index_o == BASE + 2) m_rw <= bkp_value_o[0];
                else if (bkp_index_o == BASE + 3) m_t1 <= int'(bkp_value_o);
                else if (bkp_index_o == BASE + 4) begin
                    m_tm   <= 0;
                    m_rxb  <= (m_bidx < rx_src.size()) ? rx_src[m_bidx] : 8'hEE;
                    m_bidx <= m_bidx + 1;
                end
                else if (bkp_index_o == BASE + 6 && bkp_value_o == 32'd1) m_bidx <= 0;
                else if (bkp_index_o == BASE + 9 && bkp_value_o == 32'd1) m_recv <= 1'b0;
            end
        end
    end

    // ---------------- bus / output monitor ----------------
    logic [63:0] obs_q[$];
    logic [7:0]  rx_obs[$];
    int          done_cnt = 0;
    int          hi_cnt = 0, lo_cnt = 99, win = -1;
    logic        rdy_d = 1'b0, win_bad = 1'b0, err_at_done = 1'b0;
    logic [31:0] w_idx, w_val;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt = 0; lo_cnt = 99; win = -1; rdy_d = 1'b0;
        end else begin
            if (bkp_ready_o && !rdy_d) begin
                n_cmp++;
                if (lo_cnt < GAP) begin
                    n_err++;
                    $display("FAIL bkp_gap: low %0d cycles, required >= %0d", lo_cnt, GAP);
                end
                obs_q.push_back({bkp_index_o, bkp_value_o});
                w_idx = bkp_index_o; w_val = bkp_value_o; win = 0; win_bad = 1'b0; hi_cnt = 0;
            end
            if (!bkp_ready_o && rdy_d) begin
                n_cmp++;
                if (hi_cnt != HOLD) begin
                    n_err++;
                    $display("FAIL bkp_hold: high %0d cycles, required %0d", hi_cnt, HOLD);
                end
                lo_cnt = 0;
            end
            if (bkp_ready_o) hi_cnt++; else lo_cnt++;
            if (win >= 0) begin
                if (bkp_index_o !== w_idx || bkp_value_o !== w_val) win_bad = 1'b1;
                if (win == HOLD + GAP - 1) begin
                    n_cmp++;
                    if (win_bad) begin
                        n_err++;
                        $display("FAIL bkp_stable: idx/val changed in window of idx=%0d val=%0h", w_idx, w_val);
                    end
                    win = -1;
                end else win++;
            end
            rdy_d = bkp_ready_o;
            if (rx_valid) rx_obs.push_back(rx_data);
            if (done) begin done_cnt++; err_at_done = err; end
            if (rx_valid && done) begin
                n_cmp++; n_err++;
                $display("FAIL rx_done_overlap: rx_valid=1 done=1, required not both");
            end
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic run_xfer(input logic rw, input logic [7:0] len, input int t1,
                            input bit withhold, input bit noise, input bit abort);
        logic [7:0]  txb[$];
        logic [7:0]  exp_rx[$];
        logic [63:0] exp_q[$];
        logic [7:0]  ss;
        logic [1:0]  md;
        int ti, hold_until, nshow, budget;
        bit took, finished, spurious;
        ss = 8'($urandom_range(0, 255));
        md = 2'($urandom_range(0, 3));
        rx_src = {};
        for (int i = 0; i <= int'(len); i++) begin
            txb.push_back(8'($urandom));
            rx_src.push_back(8'($urandom));
        end
        // Expected BKP write list.
        exp_q.push_back({32'd0, 32'd0});
        exp_q.push_back({32'(BASE), 32'd1});
        exp_q.push_back({32'(BASE + 1), {30'd0, md}});
        exp_q.push_back({32'(BASE + 2), {31'd0, rw}});
        exp_q.push_back({32'(BASE + 3), 32'(t1)});
        exp_q.push_back({32'(BASE + 7), {24'd0, ss}});
        exp_q.push_back({32'(BASE + 9), 32'd1});
        exp_q.push_back({32'(BASE + 9), 32'd0});
        exp_q.push_back({32'(BASE + 8), 32'd0});
        exp_q.push_back({32'(BASE + 6), 32'd0});
        exp_q.push_back({32'(BASE + 6), 32'd1});
        if (abort) begin
            exp_q.push_back({32'(BASE + 4), {24'd0, txb[0]}});
            exp_q.push_back({32'(BASE + 8), 32'd2});
            exp_q.push_back({32'(BASE + 8), 32'd0});
            exp_q.push_back({32'(BASE + 6), 32'd0});
            exp_q.push_back({32'(BASE), 32'd0});
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                exp_q.push_back({32'(BASE + 4), {24'd0, txb[i]}});
                if (rw) begin
                    exp_rx.push_back(rx_src[i]);
                    exp_q.push_back({32'd0, 32'd1});
                    exp_q.push_back({32'(BASE + 5), 32'd0});
                    exp_q.push_back({32'd0, 32'd0});
                    exp_q.push_back({32'(BASE + 9), 32'd1});
                    exp_q.push_back({32'(BASE + 9), 32'd0});
                end
                if (i < int'(len)) begin
                    exp_q.push_back({32'(BASE + 8), 32'd1});
                    exp_q.push_back({32'(BASE + 8), 32'd0});
                end else exp_q.push_back({32'(BASE + 8), 32'd2});
            end
            exp_q.push_back({32'(BASE + 8), 32'd0});
            exp_q.push_back({32'(BASE + 6), 32'd0});
        end
        obs_q = {}; rx_obs = {}; done_cnt = 0;
        // Issue command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_len = len; cmd_ss = ss; cmd_mode = md;
        cmd_t1bit = 32'(t1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL accept: busy=%0b cmd_ready=%0b err=%0b, required 1 0 0", busy, cmd_ready, err);
        end
        ti = 0; hold_until = 0; took = 0; finished = 0; spurious = 0;
        budget = 400 * (int'(len) + 1) + 1000;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (took) begin
                took = 0; ti++;
                if (withhold && ti == 1) hold_until = cyc + 150;
            end
            tx_valid = (ti < txb.size()) && (cyc >= hold_until);
            tx_data  = (ti < txb.size()) ? txb[ti] : 8'h00;
            if (noise) begin
                cmd_valid = 1'b1; cmd_rw = ~rw; cmd_len = 8'($urandom);
                cmd_ss = 8'($urandom); cmd_t1bit = $urandom;
            end
            #1;
            if (tx_ready && !tx_valid) spurious = 1;
            if (tx_ready) took = 1;
            if (done) begin cmd_valid = 1'b0; finished = 1; break; end
        end
        cmd_valid = 1'b0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!finished) begin
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        n_cmp++;
        if (spurious) begin
            n_err++; $display("FAIL tx_ready_idle: tx_ready=1 with tx_valid=0");
        end
        n_cmp++;
        if (done_cnt != 1 || err_at_done !== abort) begin
            n_err++;
            $display("FAIL done_pulse: count=%0d err=%0b, required 1 %0b", done_cnt, err_at_done, abort);
        end
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || err !== abort) begin
            n_err++;
            $display("FAIL after_done: busy=%0b cmd_ready=%0b err=%0b, required 0 1 %0b", busy, cmd_ready, err, abort);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL wr_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        nshow = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                if (nshow < 4)
                    $display("FAIL wr[%0d]: idx=%0d val=%0h, required idx=%0d val=%0h", i,
                             obs_q[i][63:32], obs_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
                nshow++;
            end
        end
        n_cmp++;
        if (rx_obs.size() != exp_rx.size()) begin
            n_err++;
            $display("FAIL rx_count: %0d bytes, required %0d", rx_obs.size(), exp_rx.size());
        end
        for (int i = 0; i < rx_obs.size() && i < exp_rx.size(); i++) begin
            n_cmp++;
            if (rx_obs[i] !== exp_rx[i]) begin
                n_err++;
                $display("FAIL rx[%0d]: %02h, required %02h", i, rx_obs[i], exp_rx[i]);
            end
        end
        $display("xfer rw=%0b len=%0d t1=%0d ss=%0d mode=%0d withhold=%0b abort=%0b writes=%0d rx=%0d",
                 rw, len, t1, ss, md, withhold, abort, obs_q.size(), rx_obs.size());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_valid = 1'b1; cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl: cmd_ready=%0b busy=%0b done=%0b err=%0b, required 1 0 0 0", cmd_ready, busy, done, err);
        end
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data: rx_valid=%0b rx_data=%02h tx_ready=%0b, required 0 00 0", rx_valid, rx_data, tx_ready);
        end
        n_cmp++;
        if (bkp_ready_o !== 1'b0 || bkp_index_o !== 32'd0 || bkp_value_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_bkp: ready=%0b idx=%0d val=%0h, required 0 0 0", bkp_ready_o, bkp_index_o, bkp_value_o);
        end
        tx_valid = 1'b0; rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0 || tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: writes=%0d tx_ready=%0b, required 0 0", obs_q.size(), tx_ready);
        end
        $display("reset checked");
    endtask

    task automatic test_reset_midxfer();
        int sz;
        bit seen;
        obs_q = {}; rx_src = {8'h11, 8'h22, 8'h33};
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_len = 8'd2; cmd_ss = 8'd3; cmd_mode = 2'd0;
        cmd_t1bit = 32'd8; tx_valid = 1'b1; tx_data = 8'h5C;
        @(posedge clk); #1; cmd_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (obs_q.size() >= 12) begin seen = 1; break; end
        end
        tx_valid = 1'b0;
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL midreset_wait: %0d writes, required >= 12", obs_q.size()); end
        repeat (20) @(negedge clk);    // busy high, DUT waiting in POLLLO
        rst_n = 1'b0;
        @(posedge clk); #1;
        sz = obs_q.size();
        n_cmp++;
        if (bkp_ready_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_out: ready=%0b busy=%0b cmd_ready=%0b, required 0 0 1", bkp_ready_o, busy, cmd_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != sz || done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_quiet: writes %0d->%0d busy=%0b, required no writes, busy 0", sz, obs_q.size(), busy);
        end
        $display("xfer reset during POLLLO, writes before reset=%0d", sz);
        run_xfer(1'b1, 8'd1, 5, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        run_xfer(1'b0, 8'd0, 8, 1'b0, 1'b0, 1'b0);          // single write byte
        run_xfer(1'b1, 8'd3, 8, 1'b0, 1'b0, 1'b0);          // four-byte read
        for (int k = 0; k < 4; k++)                         // randomized, with cmd noise
            run_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)),
                     int'($urandom_range(4, 8)), 1'b0, 1'b1, 1'b0);
        m_stuck = 1'b1;                                     // stuck busy -> abort
        run_xfer(1'b0, 8'd0, 8, 1'b0, 1'b0, 1'b1);
        m_stuck = 1'b0;
        run_xfer(1'b1, 8'd1, 6, 1'b1, 1'b0, 1'b0);          // TX withheld, then back-to-back
        run_xfer(1'b0, 8'd2, 4, 1'b0, 1'b0, 1'b0);
        test_reset_midxfer();
        run_xfer(1'b0, 8'd255, 4, 1'b0, 1'b0, 1'b0);        // 256 bytes
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
